// File: rtl/bram_dma_pkg.sv
// Shared types and defaults for the BRAM DMA read/write stages.
package bram_dma_pkg;

    localparam int PTR_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; data_o shows the head word whenever empty_o=0.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axis_bram_reader.sv
// Reads a run of sequential BRAM words and streams them out as AXI4-Stream.
// Optional BRAM_RD_PERF_EN adds a saturating stall_cycles counter port.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads (credit and wr_active permitting)
// DRAIN | all reads issued, waiting for the last beat to be accepted
// DONE  | one-cycle done pulse
module axis_bram_reader
    import bram_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PTR_WIDTH  = PTR_WIDTH_DEF,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PTR_WIDTH-1:0]  num_words,
    input  logic                  wr_active,
    output logic                  busy,
    output logic                  done,
    output logic                  dma_rd_en,
    output logic [PTR_WIDTH-1:0]  dma_read_pointer,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
`ifdef BRAM_RD_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_t             state_q;
    logic [PTR_WIDTH-1:0]  count_q;
    logic [PTR_WIDTH-1:0]  issue_cnt_q;
    logic [PTR_WIDTH-1:0]  beat_cnt_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic                  rd_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic [RD_LATENCY-1:0] pipe_q;

    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_valid;
    logic [PTR_WIDTH-1:0]  last_idx;
    logic                  issue_pending;
    logic                  credit_ok;
    logic                  can_issue;
    logic                  beat_fire;
    logic                  last_beat;
    int                    inflight;

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (pipe_q[RD_LATENCY-1]),
        .data_i  (dma_rd_data),
        .pop_i   (beat_fire),
        .data_o  (m_axis_tdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    // The read launched this cycle (rd_en_q) has not reached the pipe yet, so it is credited too.
    always_comb begin
        inflight = int'(rd_en_q);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + int'(pipe_q[i]);
        end
        fifo_valid    = !fifo_empty;
        last_idx      = count_q - {{(PTR_WIDTH-1){1'b0}}, 1'b1};
        issue_pending = (state_q == RUN) && (issue_cnt_q < count_q);
        credit_ok     = (int'(fifo_cnt) + inflight) < FIFO_DEPTH;
        can_issue     = issue_pending && !wr_active && credit_ok;
        beat_fire     = fifo_valid && m_axis_tready;
        last_beat     = beat_fire && (beat_cnt_q == last_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_en_q   <= can_issue;
            pipe_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (can_issue) begin
                rd_ptr_q    <= issue_cnt_q;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (beat_fire) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q     <= num_words;
                        issue_cnt_q <= '0;
                        beat_cnt_q  <= '0;
                        if (num_words == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_cnt_q == count_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign dma_rd_en        = rd_en_q;
    assign dma_read_pointer = rd_ptr_q;
    assign m_axis_tvalid    = fifo_valid;
    assign m_axis_tlast     = fifo_valid && (beat_cnt_q == last_idx);

`ifdef BRAM_RD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] stall_inc;

    always_comb begin
        stall_inc = 32'(issue_pending && !can_issue) + 32'(fifo_valid && !m_axis_tready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (stall_q > (32'hFFFF_FFFF - stall_inc)) begin
            stall_q <= 32'hFFFF_FFFF;
        end else begin
            stall_q <= stall_q + stall_inc;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/axis_bram_reader.md
Name: axis_bram_reader

Overview:
- Read-side DMA stage that sits directly downstream of the shared BRAM wrapper.
- On a start pulse it issues a run of sequential word reads by driving the wrapper's DMA read enable and read pointer.
- Returned words are captured after the fixed BRAM read latency and buffered in a small FIFO.
- The FIFO presents data as an AXI4-Stream master (tvalid/tready/tlast) toward the S2MM DMA engine.

Parameters:
- DATA_WIDTH, 32, BRAM/stream word width
- PTR_WIDTH, 16, width of the read pointer and word count
- RD_LATENCY, 2, cycles from dma_rd_en high to the matching word valid on dma_rd_data (range 1..4)
- FIFO_DEPTH, 4, output buffer depth in words (power of two, ≥ RD_LATENCY+1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begin transfer (ignored while busy)
- num_words  input  PTR_WIDTH  words to transfer, sampled on start
- wr_active  input  1  write path owns BRAM port A this cycle; inhibits read issue
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when the last beat is accepted
- dma_rd_en  output  1  read request to the BRAM wrapper
- dma_read_pointer  output  PTR_WIDTH  word offset, valid whenever dma_rd_en=1
- dma_rd_data  input  DATA_WIDTH  read data from the BRAM wrapper
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tlast  output  1  last beat of transfer
- m_axis_tready  input  1  downstream ready

Behaviour:
- Reset values, all outputs: 0 (busy, done, dma_rd_en, dma_read_pointer, tvalid, tlast, tdata). FIFO, counters and latency pipe are cleared. Reset mid-transfer aborts with no done pulse.
- FSM states:
  - IDLE: start with num_words≠0 → RUN, latching the count and zeroing issue_cnt/beat_cnt. start with num_words=0 → DONE (done pulses the next cycle, no beats).
  - RUN: issue reads. When issue_cnt reaches the count → DRAIN.
  - DRAIN: wait until all beats are accepted → DONE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in RUN and DRAIN.
- Issue rule: dma_rd_en and dma_read_pointer are registered and change together. A read is issued in the next cycle iff all hold:
  - state is RUN
  - issue_cnt < count
  - wr_active=0
  - fifo_count + inflight < FIFO_DEPTH
- On issue: dma_read_pointer = issue_cnt, then issue_cnt increments.
- inflight = popcount of an RD_LATENCY-bit valid shift register fed by dma_rd_en.
- Capture: when the pipe tail is 1, push dma_rd_data into the FIFO. The credit check guarantees no overflow, so a push never stalls.
- Simultaneous push and pop leaves fifo_count unchanged.
- Stream:
  - m_axis_tvalid = FIFO not empty.
  - A beat transfers on tvalid&tready; beat_cnt increments.
  - tlast=1 exactly when beat_cnt = count-1 with tvalid high.
  - tdata must hold stable while tvalid=1 and tready=0.
- Pointer arithmetic is unsigned PTR_WIDTH. count=65535 issues pointers 0..65534. No wrap; base-address addition belongs to the wrapper.
- start during RUN/DRAIN/DONE is ignored.
- wr_active asserted mid-transfer pauses issue only. Words already in flight still land and stream out.

Optional Feature:
- Macro BRAM_RD_PERF_EN.
- Defined: adds output port stall_cycles (32 bit). It counts cycles in RUN where an issue was blocked (wr_active or no credit) plus cycles with tvalid&!tready. It clears on start and saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package bram_dma_pkg holds:
  - FSM state enum rd_state_t (IDLE, RUN, DRAIN, DONE)
  - localparam PTR_WIDTH_DEF=16 and DATA_WIDTH_DEF=32
- One sub-module, sync_fifo_fwft: a first-word-fall-through synchronous FIFO parameterised by width/depth, with count output, full/empty, and async active-low reset.

Test Plan:
- BRAM model preloaded word[i]=0xA000_0000+i, num_words=8, tready=1 → 8 beats 0xA0000000..0xA0000007, tlast on beat 7, done one cycle after beat 7, pointers 0..7 each issued exactly once.
- num_words=6, tready toggles 1,0,0,1 repeating → data order intact, tdata stable during stalls, FIFO never exceeds 4, no dropped or duplicated words.
- wr_active held high for cycles 3–7 after start, num_words=5 → no dma_rd_en while wr_active=1, transfer resumes and completes with 5 correct beats.
- num_words=0 start → done pulses one cycle later, busy never rises, tvalid stays 0.
- Reset asserted after 3 of 10 beats → all outputs 0 immediately. A new start with num_words=2 then yields pointers 0,1 and beats word[0],word[1] only.
- BRAM_RD_PERF_EN defined, num_words=4, tready=0 for 10 cycles after the first tvalid → stall_cycles ≥10 at done, and it reads 0 after the next start.
